// File: rtl/seg_display_scanner.sv
// seg_display_scanner: four-digit seven-segment scanner with blanking dead-time,
// frame-aligned write commit and leading-zero suppression.
module seg_display_scanner #(
    parameter int DIV       = 50000,
    parameter int BLANK_CYC = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    input  logic        lz_en,
    output logic        wr_ack,
    output logic        frame,
    output logic [3:0]  bcd,
    output logic [3:0]  an
);
    localparam int CW = $clog2(DIV);
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [15:0]   disp, shadow;
    logic          pend, lz_q;
    logic          slot_end, boundary, blank, sup;
    assign slot_end = cnt == CW'(DIV - 1);
    assign boundary = slot_end && idx == 2'd3;
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            idx    <= '0;
            disp   <= '0;
            shadow <= '0;
            pend   <= 1'b0;
            lz_q   <= 1'b0;
            wr_ack <= 1'b0;
            frame  <= 1'b0;
        end else begin
            cnt    <= slot_end ? '0 : cnt + 1'b1;
            idx    <= slot_end ? idx + 2'd1 : idx;
            wr_ack <= 1'b0;
            frame  <= 1'b0;
            if (boundary) begin
                lz_q  <= lz_en;
                frame <= 1'b1;
                // same-cycle write bypasses the shadow so it is never lost
                if (wr_en || pend) begin
                    disp   <= wr_en ? wr_data : shadow;
                    pend   <= 1'b0;
                    wr_ack <= 1'b1;
                end
            end else if (wr_en) begin
                shadow <= wr_data;
                pend   <= 1'b1;
            end
        end
    end
    // a digit is dark when it and every more-significant digit are zero
    assign sup   = lz_q && idx != 2'd0 && (disp >> {idx, 2'b00}) == 16'h0;
    assign blank = cnt < CW'(BLANK_CYC);
    assign an    = (blank || sup) ? 4'b1111 : ~(4'b0001 << idx);
    assign bcd   = disp[{idx, 2'b00} +: 4];
endmodule

// File: tb/tb_seg_display_scanner.sv
// tb_seg_display_scanner: directed checks of scan timing, write commit,
// bypass, coalescing, leading-zero suppression and mid-run reset.
module tb_seg_display_scanner;
    logic        clk = 1'b0, rst = 1'b1, wr_en = 1'b0, lz_en = 1'b0;
    logic [15:0] wr_data = 16'h0;
    logic        wr_ack, frame;
    logic [3:0]  bcd, an;
    int          checks = 0, failures = 0, c = 0, acks = 0;
    logic [15:0] v;

    seg_display_scanner #(.DIV(8), .BLANK_CYC(2)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .lz_en(lz_en),
        .wr_ack(wr_ack), .frame(frame), .bcd(bcd), .an(an)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, c, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_an(input int cc, input logic [3:0] sup);
        logic [1:0] s;
        s = 2'((cc / 8) % 4);
        return ((cc % 8) < 2 || sup[s]) ? 4'b1111 : ~(4'b0001 << s);
    endfunction

    function automatic logic [3:0] nib(input logic [15:0] val, input int cc);
        return 4'((val >> (4 * ((cc / 8) % 4))) & 16'hF);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        c++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wr_en = 1'b0;
        lz_en = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        c = 0;
    endtask

    task automatic wr(input logic [15:0] d);
        wr_en = 1'b1;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic run_to(input int n);
        while (c < n) tick();
    endtask

    initial begin
        // reset scan
        do_reset();
        chk("reset_an", 16'(an), 16'hF);
        chk("reset_bcd", 16'(bcd), 16'h0);
        while (c <= 32) begin
            chk("scan_an", 16'(an), 16'(exp_an(c, 4'b0000)));
            chk("scan_frame", 16'(frame), 16'(c == 32));
            chk("scan_ack", 16'(wr_ack), 16'h0);
            chk("scan_bcd", 16'(bcd), 16'h0);
            if (c < 32) tick(); else break;
        end

        // mid-frame write
        do_reset();
        run_to(5);
        wr(16'h1234);
        while (c < 32) begin
            chk("mid_bcd_old", 16'(bcd), 16'h0);
            chk("mid_ack_early", 16'(wr_ack), 16'h0);
            tick();
        end
        chk("mid_ack", 16'(wr_ack), 16'h1);
        chk("mid_frame", 16'(frame), 16'h1);
        v = 16'h1234;
        while (c < 64) begin
            chk("mid_bcd", 16'(bcd), 16'(nib(v, c)));
            chk("mid_an", 16'(an), 16'(exp_an(c, 4'b0000)));
            tick();
        end
        chk("mid_frame2", 16'(frame), 16'h1);
        chk("mid_ack2", 16'(wr_ack), 16'h0);

        // coalescing
        do_reset();
        acks = 0;
        run_to(3);
        wr(16'h1111);
        run_to(20);
        wr(16'h2222);
        while (c < 64) begin
            if (c == 32) chk("coal_ack32", 16'(wr_ack), 16'h1);
            if (wr_ack) acks++;
            tick();
        end
        chk("coal_ack_count", 16'(acks), 16'h1);
        run_to(66);
        chk("coal_bcd_d0", 16'(bcd), 16'h2);
        run_to(90);
        chk("coal_bcd_d3", 16'(bcd), 16'h2);

        // boundary bypass
        do_reset();
        run_to(31);
        chk("byp_ack_pre", 16'(wr_ack), 16'h0);
        wr(16'hABCD);
        chk("byp_ack", 16'(wr_ack), 16'h1);
        chk("byp_frame", 16'(frame), 16'h1);
        run_to(34);
        while (c <= 39) begin
            chk("byp_bcd_d0", 16'(bcd), 16'hD);
            chk("byp_an_d0", 16'(an), 16'b1110);
            tick();
        end
        run_to(42);
        chk("byp_bcd_d1", 16'(bcd), 16'hC);

        // leading-zero suppression
        do_reset();
        lz_en = 1'b1;
        wr(16'h0050);
        run_to(32);
        chk("lz_ack", 16'(wr_ack), 16'h1);
        while (c < 64) begin
            chk("lz50_an", 16'(an), 16'(exp_an(c, 4'b1100)));
            chk("lz50_bcd", 16'(bcd), 16'(nib(16'h0050, c)));
            if (c == 40) wr(16'h0000); else tick();
        end
        chk("lz0_ack", 16'(wr_ack), 16'h1);
        while (c < 96) begin
            chk("lz0_an", 16'(an), 16'(exp_an(c, 4'b1110)));
            tick();
        end
        lz_en = 1'b0;

        // reset mid-operation with a pending write
        do_reset();
        run_to(3);
        wr(16'h1234);
        run_to(20);
        rst = 1'b1;
        tick();
        chk("mrst_an", 16'(an), 16'hF);
        chk("mrst_bcd", 16'(bcd), 16'h0);
        chk("mrst_frame", 16'(frame), 16'h0);
        rst = 1'b0;
        c = 0;
        while (c <= 40) begin
            chk("mrst_an_scan", 16'(an), 16'(exp_an(c, 4'b0000)));
            chk("mrst_ack", 16'(wr_ack), 16'h0);
            chk("mrst_bcd_scan", 16'(bcd), 16'h0);
            chk("mrst_frame_scan", 16'(frame), 16'(c == 32));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seg_display_scanner.md
# seg_display_scanner

Time-multiplexing controller for the board's four-digit seven-segment display on the multicycle MIPS test harness. It holds a 16-bit BCD/hex value, scans one digit at a time, and drives the 4-bit nibble into the shared BCD-to-seven-segment decoder. It drives the active-low digit enables (`an`) with a dead-time gap between digits to prevent ghosting. New values are accepted through a write handshake and committed only at frame boundaries, so a frame never shows a mix of old and new digits.

## Interface
- `DIV`, default 50000: cycles per digit slot; legal range `DIV >= 2`.
- `BLANK_CYC`, default 1000: dead cycles at the start of each slot; legal range `1 <= BLANK_CYC < DIV`.

- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `wr_en`, in, 1: write request; samples `wr_data`.
- `wr_data`, in, 16: four nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
- `lz_en`, in, 1: leading-zero suppression enable; sampled at frame boundary.
- `wr_ack`, out, 1: one-cycle pulse when a write is committed to the display.
- `frame`, out, 1: one-cycle pulse marking the first cycle of a new frame (digit 0 slot).
- `bcd`, out, 4: nibble of the current digit, to the decoder input.
- `an`, out, 4: active-low digit enables; bit i selects digit i.

## Operation
- Registers:
  - `cnt`: 0..DIV-1, slot counter.
  - `idx`: 0..3, digit index.
  - `disp[15:0]`: committed value.
  - `shadow[15:0]`: latest accepted write.
  - `pend`: write pending.
  - `lz_q`: registered copy of `lz_en`.
  - `wr_ack`, `frame`: registered pulses.
- Each cycle `cnt` increments. At `cnt == DIV-1`, `cnt` goes to 0 and `idx` goes to `idx+1` mod 4.
- Frame boundary is the edge where `cnt == DIV-1` and `idx == 3`. At that edge:
  - `lz_q <= lz_en` and `frame <= 1`.
  - If `wr_en`, `disp <= wr_data`, `pend <= 0`, `wr_ack <= 1`. This is a bypass: same-cycle data wins.
  - Otherwise, if `pend`, `disp <= shadow`, `pend <= 0`, `wr_ack <= 1`.
- On any other edge with `wr_en`: `shadow <= wr_data`, `pend <= 1`. Last write before the boundary wins, and only one ack is issued per frame.
- `wr_ack` and `frame` are 0 on every non-boundary-following cycle.
- Slot phases, decoded combinationally from registers only (no input-to-output paths):
  - BLANK (`cnt < BLANK_CYC`): `an = 4'b1111`.
  - SHOW (`cnt >= BLANK_CYC`): `an = ~(4'b0001 << idx)`, unless the digit is suppressed.
- Suppression applies when `lz_q == 1`, `idx != 0`, and every nibble of `disp` from `idx` up to 3 is zero. A suppressed digit keeps `an = 4'b1111` for the entire slot. Digit 0 is never suppressed.
- `bcd = disp[4*idx +: 4]` in both phases. Nibbles A–F pass through unchanged, so the decoder shows hex.
- Reset values:
  - `cnt`, `idx`, `disp`, `shadow`, `pend`, `lz_q`, `wr_ack`, `frame` are all 0.
  - Hence `an = 4'b1111` and `bcd = 4'h0`.
  - A pending write is discarded and no ack is issued for it.

## Timing
- Frame period is `4*DIV` cycles. Digit i SHOW occupies cycles `i*DIV + BLANK_CYC` through `i*DIV + DIV - 1` of the frame.
- After reset deassertion (first cycle is cycle 0):
  - `an = 4'b1111` for cycles 0..BLANK_CYC-1.
  - Digit 0 is enabled from cycle BLANK_CYC.
  - The first `frame` pulse is at cycle `4*DIV`.
- Write latency: `wr_ack` rises 1 to `4*DIV` cycles after the `wr_en` cycle, and coincides with `frame`. New digits are visible from that same cycle.
- `rst` mid-operation takes effect at the next edge, regardless of phase or pending state.
- `wr_en` is sampled every cycle with no backpressure. The block never stalls.

## Test plan
All scenarios use `DIV=8`, `BLANK_CYC=2`.
- **Reset scan:** release `rst` at cycle 0 with `disp=0` -> `an`=1111 in cycles 0–1, 1110 in 2–7, 1111 in 8–9, 1101 in 10–15, 1011 in 18–23, 0111 in 26–31. `frame` pulses at 32; `wr_ack` stays 0.
- **Mid-frame write:** `wr_en` with 0x1234 at cycle 5 -> `bcd` still 0 through cycle 31. At cycle 32 `wr_ack`=`frame`=1. `bcd`=4 during digit 0 and `bcd`=1 during digit 3 (cycles 58–63).
- **Coalescing:** write 0x1111 at cycle 3, then 0x2222 at cycle 20 -> exactly one `wr_ack`, at cycle 32; `disp`=0x2222.
- **Boundary bypass:** `wr_en` with 0xABCD at cycle 31 -> `wr_ack`=1 at cycle 32; `bcd`=0xD at cycles 34–39.
- **Leading-zero suppression:** `lz_en`=1 with value 0x0050 -> digits 3 and 2 hold `an`=1111 for whole slots; digit 1 shows `bcd`=5; digit 0 shows 0. With 0x0000, only digit 0 is ever enabled.
- **Reset mid-operation:** `rst` at cycle 20 with a pending write -> cycle 21: `an`=1111, `bcd`=0; no `wr_ack` follows, and the scan restarts as in the reset-scan case.
